// File: rtl/adc_uart_pkg.sv
// Shared constants and types for the ADC-to-UART framing path.
package adc_uart_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  localparam int DEF_DECIM      = 2400;
  localparam int DEF_FRAME_LEN  = 16;
  localparam int DEF_FIFO_DEPTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    DATA,
    CHK
  } frame_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output. A push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adc_uart_framer.sv
// Decimates ADC samples into a FIFO and emits framed bytes
// (A5, seq, samples, xor checksum) over a start/ready byte handshake.
module adc_uart_framer
  import adc_uart_pkg::*;
#(
  parameter int DECIM      = DEF_DECIM,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] adin_data,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  frame_state_e   state;
  frame_state_e   next_state;
  logic [7:0]     adc_q;
  logic [CW-1:0]  dcnt;
  logic           push_req;
  logic           pop;
  logic           fire;
  logic           holdoff;
  logic [LW-1:0]  byte_cnt;
  logic [7:0]     seq;
  logic [7:0]     chk;
  logic [7:0]     send_byte;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_count;

  assign push_req = enable && (dcnt == CW'(DECIM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_q <= '0;
      dcnt  <= '0;
    end else begin
      adc_q <= adin_data;
      if (enable) dcnt <= (dcnt == CW'(DECIM - 1)) ? '0 : dcnt + CW'(1);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (adc_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A pop in the same cycle frees the slot, so only push-on-full-without-pop drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    send_byte  = FRAME_HDR;
    case (state)
      IDLE: if (fifo_count >= (AW+1)'(FRAME_LEN)) next_state = HDR;
      HDR:  if (holdoff) next_state = SEQ;
      SEQ: begin
        send_byte = seq;
        if (holdoff) next_state = DATA;
      end
      DATA: begin
        send_byte = fifo_dout;
        if (holdoff && byte_cnt == LW'(FRAME_LEN - 1)) next_state = CHK;
      end
      CHK: begin
        send_byte = chk;
        if (holdoff) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A byte goes out on the first ready cycle outside the post-send holdoff;
  // the holdoff cycle is where the state advances.
  assign fire = (state != IDLE) && !holdoff && tx_ready;
  assign pop  = fire && (state == DATA) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      holdoff  <= 1'b0;
      byte_cnt <= '0;
      seq      <= '0;
      chk      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= next_state;
      tx_start <= fire;
      holdoff  <= fire;
      if (fire) tx_data <= send_byte;
      if (fire && state == SEQ)  chk <= seq;
      if (fire && state == DATA) chk <= chk ^ fifo_dout;
      if (holdoff && state == DATA)
        byte_cnt <= (byte_cnt == LW'(FRAME_LEN - 1)) ? '0 : byte_cnt + LW'(1);
      if (holdoff && state == CHK) seq <= seq + 8'd1;
    end
  end

endmodule

// File: doc/adc_uart_framer.md
# adc_uart_framer

Sits between the 8-bit parallel ADC input and the UART transmitter. It decimates the ADC sample stream and buffers samples in a FIFO. It packs them into fixed-length frames with header, sequence number and checksum. It drives the transmitter one byte at a time over a start/ready handshake.

## Interface
- DECIM, 2400: clock cycles per captured sample. Minimum 2. At 24 MHz this gives 10 kS/s.
- FRAME_LEN, 16: samples per frame. Range 1..FIFO_DEPTH.
- FIFO_DEPTH, 32: sample FIFO depth. Power of two.
- clk  in  1  system clock, the 24 MHz HFOSC output.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enable  in  1  when 0, the decimation counter holds and no samples are captured. Frames in progress still complete.
- adin_data  in  8  ADC output, sampled on clk.
- tx_ready  in  1  transmitter idle and able to accept a byte.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  8  byte to transmit; registered.
- overflow  out  1  sticky; set when a sample is dropped; cleared only by reset.
- drop_count  out  8  saturating count of dropped samples; stops at 255.

## Operation
- Input register: adin_data is registered every cycle into adc_q.
- Decimation counter `dcnt` counts 0..DECIM-1 while enable=1 and wraps to 0.
  - When dcnt==DECIM-1, push adc_q into the FIFO.
  - enable=0 freezes dcnt at its current value.
- Push when full:
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped.
  - overflow <= 1, and drop_count increments unless it is already 255.
  - Push and pop in the same cycle on a full FIFO: the push is accepted.
- Frame format, in byte order:
  - 0xA5
  - seq
  - FRAME_LEN samples, oldest first
  - chk = XOR of seq and all samples
- seq is 8 bits, increments after each complete frame, and wraps 255->0.
- FSM states and transitions:
  - IDLE -> HDR when FIFO count >= FRAME_LEN.
  - HDR sends 0xA5, then -> SEQ.
  - SEQ sends seq; chk <= seq; then -> DATA.
  - DATA pops one sample per byte sent; chk ^= sample; after FRAME_LEN bytes -> CHK.
  - CHK sends chk; seq++; then -> IDLE.
- Sending a byte in any state:
  - Wait until tx_ready=1.
  - Load tx_data and pulse tx_start for exactly one cycle.
  - Enter a one-cycle holdoff in which tx_ready is ignored.
  - Then advance the state.
  - The next byte waits for tx_ready=1 again.
- In DATA, the FIFO pop occurs in the same cycle as the tx_start pulse for that sample.
- Sampling and pushing continue during frame transmission.
- A frame is never started with fewer than FRAME_LEN samples buffered. DATA therefore never pops an empty FIFO.

## Timing
- Reset values:
  - tx_start=0, tx_data=0x00, overflow=0, drop_count=0.
  - seq=0, dcnt=0, FIFO empty, FSM=IDLE, holdoff cleared.
- Reset mid-frame: the frame is abandoned immediately. After reset, the first frame uses seq=0.
- Capture latency: the push in the cycle where dcnt==DECIM-1 stores adin_data as presented one cycle earlier.
- Frame start latency:
  - The FIFO count reaches FRAME_LEN at edge N.
  - IDLE->HDR at edge N+1.
  - tx_start for 0xA5 is no earlier than edge N+2, and only if tx_ready=1.
- tx_data stays stable from its tx_start pulse until the next tx_start pulse.
- tx_start is never asserted while tx_ready=0, and never in two consecutive cycles.
- Minimum byte spacing is 2 cycles, set by the holdoff. In practice spacing is governed by tx_ready.
- FIFO count is updated in the cycle after the push or pop.
- The IDLE check uses the registered count.

## Structure
- Package adc_uart_pkg:
  - FRAME_HDR = 8'hA5.
  - FSM state enum: IDLE, HDR, SEQ, DATA, CHK.
  - Default parameter constants.
- Sub-module sync_fifo, parameterised on width and depth.
  - Single clock, synchronous active-high reset.
  - Ports: push, pop, din, dout (first-word fall-through), full, empty, count.
- The top level instantiates adc_uart_framer between adin_data and uart_tx. It drives uart_tx.start from tx_start and uart_tx.data from tx_data.

## Test plan
- Basic frame:
  - Stimulus: DECIM=4, FRAME_LEN=4, adin_data ramp 0x10,0x11,…; UART model with ready low for 10 cycles after each start.
  - Required response: bytes A5,00,10,11,12,13,chk=0x00^10^11^12^13=0x00.
- Sequence wrap:
  - Stimulus: transmit 257 frames.
  - Required response: seq fields run 00..FF then 00; every checksum matches.
- Overflow:
  - Stimulus: hold tx_ready=0 with DECIM=2 and FIFO_DEPTH=8 for 40 cycles.
  - Required response: FIFO holds the first 8 samples; overflow=1; drop_count equals the pushes beyond 8. After release, the first frame carries the 8 oldest samples.
- Handshake:
  - Stimulus: toggle tx_ready randomly.
  - Required response: tx_start is never high while tx_ready=0; no back-to-back pulses; tx_data is stable between pulses.
- Reset mid-frame:
  - Stimulus: assert reset during the DATA state.
  - Required response: the next cycle shows tx_start=0 and overflow=0. The following frame starts with A5,00 once FRAME_LEN new samples are buffered.
- Enable gating:
  - Stimulus: enable=0 for 100 cycles.
  - Required response: no pushes occur; dcnt holds. After enable returns to 1, capture resumes at the held dcnt value.
